// File: rtl/half_adder.sv
// ---------------------------------------------------------------------------
// half_adder
//
// Registered array of W independent one-bit half adders. Each lane produces
// Sum[i] = A[i] ^ B[i] and C[i] = A[i] & B[i]; no carry moves between lanes.
// Results appear one clock after an accepted input (in_valid=1) and are held
// while in_valid=0. No backpressure: one result per cycle.
//
// Optional feature (macro HALF_ADDER_CARRY_CNT_EN):
//   adds a 16-bit saturating counter, carry_cnt, of accepted inputs whose
//   carry vector is nonzero. With the macro undefined, the port and its
//   logic are absent and everything else is unchanged.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   qualifies A/B this cycle
//   A, B       in   [W-1:0] operand vectors
//   out_valid  out  one-cycle pulse per accepted input (registered)
//   C          out  [W-1:0] per-lane carry (registered, held when idle)
//   Sum        out  [W-1:0] per-lane sum (registered, held when idle)
//   carry_cnt  out  [15:0] saturating carry-event count (macro only)
// ---------------------------------------------------------------------------
module half_adder #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         out_valid,
  output logic [W-1:0] C,
  output logic [W-1:0] Sum
`ifdef HALF_ADDER_CARRY_CNT_EN
  ,
  output logic [15:0]  carry_cnt
`endif
);

  logic [W-1:0] sum_next;
  logic [W-1:0] carry_next;

  assign sum_next   = A ^ B;
  assign carry_next = A & B;

  // Operands are only looked at when in_valid is high, so undriven A/B
  // during idle cycles cannot reach the registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      C         <= '0;
      Sum       <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        C   <= carry_next;
        Sum <= sum_next;
      end
    end
  end

`ifdef HALF_ADDER_CARRY_CNT_EN
  logic carry_event;

  assign carry_event = in_valid && (|carry_next);

  // Saturates at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_cnt <= '0;
    end else if (carry_event && (carry_cnt != 16'hFFFF)) begin
      carry_cnt <= carry_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_half_adder.sv
module tb_half_adder;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         out_valid;
  logic [W-1:0] C;
  logic [W-1:0] Sum;
`ifdef HALF_ADDER_CARRY_CNT_EN
  logic [15:0]  carry_cnt;
`endif

  half_adder #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .C         (C),
    .Sum       (Sum)
`ifdef HALF_ADDER_CARRY_CNT_EN
    ,
    .carry_cnt (carry_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] c;
    logic [W-1:0] s;
  } result_t;

  result_t     exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          chk_on = 0;
  bit          exp_ov = 0;
  logic [W-1:0] hold_c = '0;
  logic [W-1:0] hold_s = '0;
  int          exp_cnt = 0;

  // Reference: each lane adds its two bits as integers; the low digit is
  // the sum and the high digit is the carry.
  function automatic result_t ref_add(input logic [W-1:0] a, input logic [W-1:0] b);
    result_t r;
    for (int i = 0; i < W; i++) begin
      int t;
      t = int'(a[i]) + int'(b[i]);
      r.s[i] = (t % 2) == 1;
      r.c[i] = (t / 2) == 1;
    end
    return r;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle, then advance the model to what the DUT shows after the edge.
  task automatic cycle(input bit r, input bit v, input logic [W-1:0] a, input logic [W-1:0] b);
    result_t res;
    rst = r; in_valid = v; A = a; B = b;
    @(posedge clk);
    if (r) begin
      exp_ov = 0; hold_c = '0; hold_s = '0; exp_cnt = 0;
    end else if (v) begin
      res = ref_add(a, b);
      exp_q.push_back(res);
      exp_ov = 1; hold_c = res.c; hold_s = res.s;
      if (res.c != '0 && exp_cnt < 65535) exp_cnt++;
    end else begin
      exp_ov = 0;
    end
    chk_on = 1;
    #1;
  endtask

  // Monitor: pops an expected result whenever the DUT presents one.
  always @(negedge clk) begin
    if (chk_on) begin
      check("out_valid", out_valid, exp_ov);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          result_t e;
          e = exp_q.pop_front();
          check("C", C, e.c);
          check("Sum", Sum, e.s);
        end
      end else begin
        check("C_held", C, hold_c);
        check("Sum_held", Sum, hold_s);
      end
`ifdef HALF_ADDER_CARRY_CNT_EN
      check("carry_cnt", carry_cnt, exp_cnt);
`endif
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; in_valid = 1; A = '1; B = '1;
    #1;
    // Reset with valid operands present: input discarded.
    cycle(1, 1, 2'b11, 2'b11);
    cycle(1, 1, 2'b11, 2'b11);
    check("reset_C", C, 0);
    check("reset_Sum", Sum, 0);
    check("reset_out_valid", out_valid, 0);

    // Directed sequence.
    cycle(0, 1, 2'b00, 2'b00);
    cycle(0, 1, 2'b00, 2'b01);
    cycle(0, 1, 2'b10, 2'b00);
    cycle(0, 1, 2'b11, 2'b11);
    check("all_ones_C", C, 2'b11);
    check("all_ones_Sum", Sum, 2'b00);

    // Hold with random idle operands.
    cycle(0, 1, 2'b11, 2'b01);
    for (int i = 0; i < 3; i++)
      cycle(0, 0, W'($urandom), W'($urandom));
    check("hold_C", C, 2'b01);
    check("hold_Sum", Sum, 2'b10);
    check("hold_out_valid", out_valid, 0);

    // Exhaustive, back-to-back.
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        cycle(0, 1, W'(a), W'(b));

    // Random traffic with sporadic resets.
    for (int i = 0; i < 300; i++)
      cycle(($urandom_range(0, 24) == 0), $urandom_range(0, 1), W'($urandom), W'($urandom));

    // Mid-stream reset, then resume.
    cycle(0, 1, 2'b01, 2'b11);
    cycle(0, 1, 2'b11, 2'b10);
    cycle(1, 1, 2'b11, 2'b11);
    check("midrst_C", C, 0);
    check("midrst_Sum", Sum, 0);
    check("midrst_out_valid", out_valid, 0);
    cycle(0, 1, 2'b10, 2'b11);
    check("resume_C", C, 2'b10);
    check("resume_Sum", Sum, 2'b01);

`ifdef HALF_ADDER_CARRY_CNT_EN
    cycle(1, 0, 2'b00, 2'b00);
    cycle(0, 1, 2'b01, 2'b01);
    cycle(0, 1, 2'b10, 2'b01);
    cycle(0, 1, 2'b11, 2'b10);
    cycle(0, 1, 2'b01, 2'b10);
    cycle(0, 1, 2'b11, 2'b11);
    cycle(0, 0, 2'b11, 2'b11);
    check("cnt_three", carry_cnt, 3);

    // Walk the counter to FFFE, then past saturation.
    cycle(1, 0, 2'b00, 2'b00);
    for (int i = 0; i < 65534; i++)
      cycle(0, 1, 2'b01, 2'b11);
    check("cnt_preload", carry_cnt, 16'hFFFE);
    for (int i = 0; i < 3; i++)
      cycle(0, 1, 2'b11, 2'b11);
    check("cnt_saturate", carry_cnt, 16'hFFFF);
`endif

    cycle(0, 0, 2'b00, 2'b00);
    cycle(0, 0, 2'b00, 2'b00);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
